// File: rtl/fifo_window_ctrl_if.sv
// Control/status bundle between the layer FSM, IFM RAM, window FIFO and MAC array.
// master = sequencer side, slave = surrounding system side.
interface fifo_window_ctrl_if #(
   parameter int unsigned ADDRESS_SIZE_IFM = 10,
   parameter int unsigned ROW_W            = 5,
   parameter int unsigned COL_W            = 4
);
   logic                        start;
   logic                        ready_next;
   logic                        ifm_enable_read;
   logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A;
   logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_B;
   logic                        fifo_enable;
   logic                        window_valid;
   logic [ROW_W-1:0]            window_row;
   logic [COL_W-1:0]            window_col;
   logic                        busy;
   logic                        done;

   modport master (
      input  start, ready_next,
      output ifm_enable_read, ifm_address_read_A, ifm_address_read_B, fifo_enable,
             window_valid, window_row, window_col, busy, done
   );

   modport slave (
      output start, ready_next,
      input  ifm_enable_read, ifm_address_read_A, ifm_address_read_B, fifo_enable,
             window_valid, window_row, window_col, busy, done
   );
endinterface

// File: rtl/fifo_window_ctrl.sv
// Sequencer for the dual-input 5x5 conv window FIFO: reads the IFM two pixels per
// cycle, shifts the FIFO and flags cycles where the taps hold a non-wrapping window.
module fifo_window_ctrl #(
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned IFM_SIZE         = 32,
   parameter int unsigned KERNAL_SIZE      = 5,
   parameter int unsigned ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE),
   parameter int unsigned OUT_COLS         = (IFM_SIZE-KERNAL_SIZE+1)/2,
   parameter int unsigned OUT_ROWS         = IFM_SIZE-KERNAL_SIZE+1
) (
   input logic                clk,
   input logic                reset,
   fifo_window_ctrl_if.master bus
);
   localparam int unsigned PAIR_W    = ADDRESS_SIZE_IFM - 1;
   localparam int unsigned POS_W     = $clog2(IFM_SIZE);
   localparam int unsigned WROW_W    = $clog2(OUT_ROWS);
   localparam int unsigned WCOL_W    = $clog2(OUT_COLS);
   localparam int unsigned LAST_PAIR = IFM_SIZE*IFM_SIZE/2 - 1;
   localparam int unsigned EDGE      = KERNAL_SIZE - 1;

   if (DATA_WIDTH == 0 || (IFM_SIZE % 2) != 0 || KERNAL_SIZE > IFM_SIZE) begin : g_bad_cfg
      $error("fifo_window_ctrl: unsupported parameter combination");
   end

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state;
   logic [PAIR_W-1:0] pair;
   logic [POS_W-1:0]  rd_row;
   logic [POS_W-1:0]  rd_col;
   logic [POS_W-1:0]  s1_row;
   logic [POS_W-1:0]  s1_col;
   logic              drain_cnt;
   logic              run_c;
   logic              issue_c;
   logic              qualify_c;

   // Read strobe follows ready_next directly so a stall leaves only one shift in flight.
   assign run_c   = (state == RUN);
   assign issue_c = run_c && bus.ready_next;

   assign bus.ifm_enable_read    = issue_c;
   assign bus.ifm_address_read_A = run_c ? {pair, 1'b0} : '0;
   assign bus.ifm_address_read_B = run_c ? {pair, 1'b1} : '0;

   // Newest pixel of the shift now in the FIFO is past the kernel edge in both axes.
   assign qualify_c = bus.fifo_enable && (s1_row >= POS_W'(EDGE)) && (s1_col >= POS_W'(EDGE));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         pair             <= '0;
         rd_row           <= '0;
         rd_col           <= '0;
         s1_row           <= '0;
         s1_col           <= '0;
         drain_cnt        <= 1'b0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.fifo_enable  <= 1'b0;
         bus.window_valid <= 1'b0;
         bus.window_row   <= '0;
         bus.window_col   <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state    <= RUN;
                  bus.busy <= 1'b1;
                  pair     <= '0;
                  rd_row   <= '0;
                  rd_col   <= '0;
               end
            end
            RUN: begin
               if (issue_c) begin
                  pair <= pair + PAIR_W'(1);
                  // rd_col tracks the even pixel of the pair being read
                  if (rd_col == POS_W'(IFM_SIZE-2)) begin
                     rd_col <= '0;
                     rd_row <= rd_row + POS_W'(1);
                  end else begin
                     rd_col <= rd_col + POS_W'(2);
                  end
                  if (pair == PAIR_W'(LAST_PAIR)) begin
                     state     <= DRAIN;
                     drain_cnt <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt) begin
                  state    <= DONE;
                  bus.done <= 1'b1;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase

         // RAM read latency of one cycle: shift one cycle after the read
         bus.fifo_enable <= issue_c;
         if (issue_c) begin
            s1_row <= rd_row;
            s1_col <= rd_col + POS_W'(1);
         end

         bus.window_valid <= qualify_c;
         if (qualify_c) begin
            bus.window_row <= WROW_W'(s1_row - POS_W'(EDGE));
            bus.window_col <= WCOL_W'((s1_col - POS_W'(EDGE)) >> 1);
         end
      end
   end
endmodule

// File: tb/tb_fifo_window_ctrl.sv
// Scoreboard bench for fifo_window_ctrl: expected windows are queued at start,
// a negedge monitor pops and compares each window_valid, address and done.
module tb_fifo_window_ctrl;
   localparam int IFM_SIZE    = 32;
   localparam int KERNAL_SIZE = 5;
   localparam int NPAIRS      = IFM_SIZE*IFM_SIZE/2;
   localparam int NWIN        = 392;
   localparam int DONE_T      = 514;

   typedef struct {
      int t;
      int row;
      int col;
   } win_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fifo_window_ctrl_if #(.ADDRESS_SIZE_IFM(10), .ROW_W(5), .COL_W(4)) bus ();

   fifo_window_ctrl #(
      .DATA_WIDTH (32),
      .IFM_SIZE   (IFM_SIZE),
      .KERNAL_SIZE(KERNAL_SIZE)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   int   run0        = 0;
   int   exp_pair    = 0;
   int   exp_done_t  = -1;
   int   n_win       = 0;
   int   n_done      = 0;
   int   n_fe        = 0;
   win_t exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (run cycle %0d)", name, act, exp, cyc - run0);
      end
   endtask

   // Monitor: compares every DUT event against the scoreboard/model
   always @(negedge clk) begin
      win_t e;
      if (reset) begin
         if (bus.window_valid) begin
            n_win++;
            if (exp_q.size() == 0) begin
               check("extra_window", n_win, 0);
            end else begin
               e = exp_q.pop_front();
               check("win_time", cyc - run0, e.t);
               check("win_row", int'(bus.window_row), e.row);
               check("win_col", int'(bus.window_col), e.col);
            end
         end
         if (bus.ifm_enable_read) begin
            check("addr_A", int'(bus.ifm_address_read_A), 2*exp_pair);
            check("addr_B", int'(bus.ifm_address_read_B), 2*exp_pair + 1);
            exp_pair++;
         end
         if (bus.fifo_enable) n_fe++;
         if (bus.done) begin
            n_done++;
            check("done_time", cyc - run0, exp_done_t);
         end
      end
   end

   task automatic push_run(input int stall_at, input int stall_len);
      for (int k = 0; k < NPAIRS; k++) begin
         int p;
         int r;
         int c;
         int t;
         p = 2*k + 1;
         r = p / IFM_SIZE;
         c = p % IFM_SIZE;
         t = k + 2;
         if (stall_len > 0 && k >= stall_at) t += stall_len;
         if (r >= KERNAL_SIZE-1 && c >= KERNAL_SIZE-1)
            exp_q.push_back('{t, r-(KERNAL_SIZE-1), (c-(KERNAL_SIZE-1))/2});
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of RUN cycle 0
   task automatic start_run(input int stall_at, input int stall_len);
      exp_q.delete();
      exp_pair   = 0;
      n_win      = 0;
      n_done     = 0;
      n_fe       = 0;
      push_run(stall_at, stall_len);
      exp_done_t = DONE_T + stall_len;
      bus.start  = 1'b1;
      run0       = cyc + 1;
      @(posedge clk); #1;
      bus.start  = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc - run0 < n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_window_valid"}, int'(bus.window_valid), 0);
      check({tag, "_fifo_enable"}, int'(bus.fifo_enable), 0);
      check({tag, "_enable_read"}, int'(bus.ifm_enable_read), 0);
      check({tag, "_addr_A"}, int'(bus.ifm_address_read_A), 0);
      check({tag, "_addr_B"}, int'(bus.ifm_address_read_B), 0);
      check({tag, "_window_row"}, int'(bus.window_row), 0);
      check({tag, "_window_col"}, int'(bus.window_col), 0);
      check({tag, "_busy"}, int'(bus.busy), 0);
      check({tag, "_done"}, int'(bus.done), 0);
   endtask

   task automatic end_run(input string tag);
      check({tag, "_windows"}, n_win, NWIN);
      check({tag, "_queue_left"}, exp_q.size(), 0);
      check({tag, "_dones"}, n_done, 1);
      check({tag, "_shifts"}, n_fe, NPAIRS);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got cycle %0d expected < 5000", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.start      = 1'b0;
      bus.ready_next = 1'b1;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("rst");
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Run A: no stall, start pulses at RUN cycle 50 and in the DONE cycle
      start_run(0, 0);
      wait_cyc(50);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_cyc(513);
      @(negedge clk);
      check("a_busy_513", int'(bus.busy), 1);
      check("a_done_513", int'(bus.done), 0);
      wait_cyc(514);
      bus.start = 1'b1;
      @(negedge clk);
      check("a_done_514", int'(bus.done), 1);
      check("a_busy_514", int'(bus.busy), 1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("a_done_515", int'(bus.done), 0);
      check("a_busy_515", int'(bus.busy), 0);
      repeat (20) @(posedge clk);
      #1;
      check("a_busy_after", int'(bus.busy), 0);
      check("a_read_after", int'(bus.ifm_enable_read), 0);
      end_run("a");

      // Run B: ready_next low for RUN cycles 100..109
      start_run(100, 10);
      wait_cyc(100);
      bus.ready_next = 1'b0;
      @(negedge clk);
      check("b_skid_shift", int'(bus.fifo_enable), 1);
      check("b_stall_read", int'(bus.ifm_enable_read), 0);
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (i == 10) bus.ready_next = 1'b1;
         @(negedge clk);
         check("b_stall_shift", int'(bus.fifo_enable), 0);
         check("b_stall_read", int'(bus.ifm_enable_read), (i == 10) ? 1 : 0);
      end
      check("b_resume_addr", int'(bus.ifm_address_read_A), 200);
      @(posedge clk); #1;
      @(negedge clk);
      check("b_resume_shift", int'(bus.fifo_enable), 1);
      wait_cyc(540);
      end_run("b");

      // Run C: asynchronous reset mid-run
      start_run(0, 0);
      wait_cyc(200);
      reset = 1'b0;
      #1;
      check_idle("c_rst");
      repeat (5) @(posedge clk);
      #1;
      check("c_no_done", n_done, 0);
      check("c_busy_held", int'(bus.busy), 0);
      exp_q.delete();
      reset = 1'b1;
      @(posedge clk); #1;

      // Run D: clean run after reset
      start_run(0, 0);
      wait_cyc(540);
      end_run("d");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fifo_window_ctrl.md
# fifo_window_ctrl

Sequencer for the dual-input convolution window FIFO of a 5x5 conv layer. Reads the input feature map (IFM) from its RAM two pixels per cycle, drives the FIFO shift enable, and tracks the position of the newest pixel. Flags each cycle in which the FIFO taps hold a complete, non-wrapping KERNAL_SIZE x KERNAL_SIZE window, and tags it with its output coordinates. Sits between the layer top-level control FSM (start/done) and the FIFO plus MAC array (downstream ready).

## Interface
- DATA_WIDTH, 32, pixel width (pass-through only; no data path inside this block)
- IFM_SIZE, 32, IFM row length and column count; must be even
- KERNAL_SIZE, 5, window edge; KERNAL_SIZE <= IFM_SIZE
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), IFM RAM address width
- OUT_COLS, (IFM_SIZE-KERNAL_SIZE+1)/2, windows per row; 14 at the defaults
- OUT_ROWS, IFM_SIZE-KERNAL_SIZE+1, window rows; 28 at the defaults
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  one-cycle request to process one IFM; ignored while busy
- ready_next  in  1  downstream can accept windows; low stalls new reads
- ifm_enable_read  out  1  IFM RAM read strobe
- ifm_address_read_A  out  ADDRESS_SIZE_IFM  even pixel address (drives fifo_data_in_2)
- ifm_address_read_B  out  ADDRESS_SIZE_IFM  ifm_address_read_A+1 (drives fifo_data_in)
- fifo_enable  out  1  FIFO shift strobe
- window_valid  out  1  FIFO taps hold a valid window this cycle
- window_row  out  $clog2(OUT_ROWS)  output row of the current window
- window_col  out  $clog2(OUT_COLS)  output column of the current window
- busy  out  1  high from the cycle after start until done, inclusive
- done  out  1  one-cycle pulse after the last window

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DRAIN after issuing pair index k = IFM_SIZE*IFM_SIZE/2 - 1.
  - DRAIN holds 2 cycles, then -> DONE.
  - DONE holds 1 cycle (done=1), then -> IDLE.
- In RUN: ifm_enable_read = ready_next. Pair counter k increments on each issued read; ifm_address_read_A = 2k.
- The IFM RAM has 1-cycle read latency. fifo_enable is ifm_enable_read registered, so each read produces exactly one shift.
- Newest pixel after a shift is index p = 2k+1, with row r = p / IFM_SIZE and col c = p % IFM_SIZE. Use row/col counters, not division.
- window_valid is asserted, registered, in the cycle after the shift (when the FIFO contents are updated), iff r >= KERNAL_SIZE-1 and c >= KERNAL_SIZE-1.
- Output coordinates: window_row = r-(KERNAL_SIZE-1), window_col = (c-(KERNAL_SIZE-1))/2. Both hold their value when window_valid = 0.
- Column counter wraps from IFM_SIZE-1 to 0 and increments the row counter. Columns 0..KERNAL_SIZE-2 never assert window_valid; this excludes row-wrapping windows.
- Total window_valid pulses per IFM = OUT_ROWS*OUT_COLS = 392 at the defaults.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset mid-operation returns the block to IDLE immediately. No done pulse is issued.
- start sampled at edge t0 -> RUN at t0+1. The first read (address 0) is issued in that cycle, RUN cycle 0.
- With no stall, the read for pair k is issued at RUN cycle k, fifo_enable asserts at k+1, and window_valid asserts at k+2.
- Skid of 1: after ready_next falls, exactly one in-flight shift still occurs. Its window_valid, if qualified, is still asserted, and downstream must absorb it.
- ready_next low in DRAIN/DONE has no effect.
- start in any state other than IDLE is ignored. start coinciding with the DONE cycle is ignored.
- busy = (state != IDLE).

## Test plan
- Reset, then start with ready_next=1 -> ifm_address_read_A steps 0,2,...,1022. The first window_valid is at RUN cycle 68 (k=66, newest pixel 133) with row 0, col 0.
- Full run, no stall -> 392 window_valid pulses. The last is at RUN cycle 513 with row 27, col 13. done pulses at cycle 514; busy falls at 515.
- Row boundary -> no window_valid for newest-pixel columns 1 and 3 of any row. For row 5 the first valid window has col 0, row 1.
- Drop ready_next for 10 cycles at RUN cycle 100 -> exactly one more fifo_enable, then none for 10 cycles. Reads resume at the same address; still 392 windows in total.
- Assert reset (low) at RUN cycle 200 -> all outputs 0 asynchronously and no done. A new start after release gives a clean full run.
- Pulse start at RUN cycle 50 and in the DONE cycle -> both ignored; exactly one done.
